// File: rtl/riscv_pkg.sv
// Shared definitions for the front end of the pipeline.
//   NOP_INSTR      canonical bubble instruction (addi x0,x0,0)
//   J_*            jump-type encodings from control
//   fetch_state_t  fetch FSM states
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_JAL  = 2'b01;
    localparam logic [1:0] J_JALR = 2'b10;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_target_gen.sv
// Redirect detection and target computation for the fetch stage.
// Purely combinational.
// Ports:
//   PCSrc, J      branch-taken flag and jump type from control
//   br_pc         PC of the resolving branch/jump
//   ImmExt        sign-extended immediate of that instruction
//   jalr_base     rs1+imm from the ALU (JALR target before LSB clear)
//   redirect      the PC must be redirected this cycle
//   target        word-aligned redirect target (bits [1:0] forced to 00)
//   misalign_raw  the raw target had bit 1 set (only meaningful with redirect)
module pc_target_gen
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            PCSrc,
    input  logic [1:0]      J,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] jalr_base,
    output logic            redirect,
    output logic [XLEN-1:0] target,
    output logic            misalign_raw
);

    logic [XLEN-1:0] target_raw;

    always_comb begin
        redirect = PCSrc | (J == J_JAL) | (J == J_JALR);
        // JALR clears bit 0 of rs1+imm; everything else is PC-relative and wraps.
        if (J == J_JALR) begin
            target_raw = jalr_base & ~XLEN'(1);
        end else begin
            target_raw = br_pc + ImmExt;
        end
        misalign_raw = redirect & target_raw[1];
        target       = target_raw & ~XLEN'(3);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory over a
// req/valid handshake and presents instr/pc/pcplus4 to decode.
//
// Handshakes:
//   memory: imem_req/imem_addr stay asserted and stable until imem_valid
//           returns the word; at most one request is outstanding.
//   decode: a word transfers on a cycle with instr_valid=1 and stall=0; while
//           stall=1 instr_o/pc_o/instr_valid are held.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall                 decode cannot accept
//   PCSrc, J              redirect controls from the control decoder
//   br_pc, ImmExt         branch/JAL target operands
//   jalr_base             JALR target before LSB clear
//   imem_req, imem_addr   fetch request to instruction memory
//   imem_rdata, imem_valid  instruction memory response
//   instr_o, pc_o, pcplus4_o, instr_valid  instruction to decode
//   misalign              one-cycle pulse when a redirect target had bit 1 set
//   fsm_state             current FSM state (debug)
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            PCSrc,
    input  logic [1:0]      J,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] jalr_base,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pcplus4_o,
    output logic            instr_valid,
    output logic            misalign,
    output fetch_state_t    fsm_state
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;          // address of the current/next fetch
    logic [XLEN-1:0] pend_pc_q, pend_pc_d; // redirect target parked behind a discard
    logic            discard_q, discard_d;
    logic [31:0]     skid_q, skid_d;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_o_d;
    logic            valid_d;
    logic            misalign_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            misalign_raw;

    pc_target_gen #(.XLEN(XLEN)) u_target (
        .PCSrc        (PCSrc),
        .J            (J),
        .br_pc        (br_pc),
        .ImmExt       (ImmExt),
        .jalr_base    (jalr_base),
        .redirect     (redirect),
        .target       (target),
        .misalign_raw (misalign_raw)
    );

    // pc_q only moves when no request is outstanding, so it doubles as the
    // stable fetch address.
    assign imem_req  = (state_q == REQ) || (state_q == WAIT);
    assign imem_addr = pc_q;
    assign fsm_state = state_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        discard_d  = discard_q;
        skid_d     = skid_q;
        instr_d    = instr_o;
        pc_o_d     = pc_o;
        valid_d    = instr_valid;
        misalign_d = 1'b0;

        // Decode takes whatever is presented when not stalled; without a new
        // word the output empties to a NOP bubble.
        if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end

        if (redirect) begin
            misalign_d = misalign_raw;
            valid_d    = 1'b0;
            instr_d    = NOP;
            unique case (state_q)
                REQ, WAIT: begin
                    if (imem_valid) begin
                        // Response in the redirect cycle belongs to the old path.
                        pc_d      = target;
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        // Keep the address stable; drop the response when it lands.
                        pend_pc_d = target;
                        discard_d = 1'b1;
                        state_d   = WAIT;
                    end
                end
                default: begin
                    pc_d      = target;
                    discard_d = 1'b0;
                    state_d   = REQ;
                end
            endcase
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_d = REQ;
                end
                REQ, WAIT: begin
                    if (imem_valid) begin
                        if (discard_q) begin
                            pc_d      = pend_pc_q;
                            discard_d = 1'b0;
                            state_d   = REQ;
                        end else if (!stall) begin
                            instr_d = imem_rdata;
                            pc_o_d  = pc_q;
                            valid_d = 1'b1;
                            pc_d    = pc_q + XLEN'(4);
                            state_d = REQ;
                        end else begin
                            // pc_q still names the skid word until it is presented.
                            skid_d  = imem_rdata;
                            state_d = HOLD;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d = skid_q;
                        pc_o_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = REQ;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            pend_pc_q   <= RESET_PC;
            discard_q   <= 1'b0;
            skid_q      <= NOP;
            instr_o     <= NOP;
            pc_o        <= RESET_PC;
            pcplus4_o   <= RESET_PC + XLEN'(4);
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            discard_q   <= discard_d;
            skid_q      <= skid_d;
            instr_o     <= instr_d;
            pc_o        <= pc_o_d;
            pcplus4_o   <= pc_o_d + XLEN'(4);
            instr_valid <= valid_d;
            misalign    <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import riscv_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        stall = 1'b0, PCSrc = 1'b0;
    logic [1:0]  J = 2'b00;
    logic [31:0] br_pc = '0, ImmExt = '0, jalr_base = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [31:0] instr_o, pc_o, pcplus4_o;
    logic        instr_valid, misalign;
    fetch_state_t fsm_state;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .PCSrc(PCSrc), .J(J),
        .br_pc(br_pc), .ImmExt(ImmExt), .jalr_base(jalr_base),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .instr_o(instr_o), .pc_o(pc_o),
        .pcplus4_o(pcplus4_o), .instr_valid(instr_valid), .misalign(misalign),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;
    int delivered = 0;
    logic [31:0] mpc;        // PC of the next instruction decode must receive
    logic        exp_mis;
    logic        bubble;
    logic [31:0] exp_q[$];   // expected delivered (pc) stream for the random phase

    // memory responder state
    logic        busy;
    int          wait_left;
    int          next_lat;
    logic [31:0] held_addr;
    logic        stray;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[9:2] ^ 8'hC3, a[23:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0; PCSrc = 1'b0; J = 2'b00;
        br_pc = '0; ImmExt = '0; jalr_base = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        busy = 1'b0; wait_left = 0; stray = 1'b0;
        mpc = 32'h0; exp_mis = 1'b0; bubble = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr_o, NOP_INSTR);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pcplus4", pcplus4_o, 32'h4);
        chk("rst_valid", instr_valid, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_state", 32'(fsm_state), 32'(BOOT));
        rst_n = 1'b1;
    endtask

    // One cycle: check presented outputs against the model, apply inputs,
    // answer the memory, advance to just after the next rising edge.
    task automatic step(input logic st, input logic ps, input logic [1:0] jj,
                        input logic [31:0] bp, input logic [31:0] im, input logic [31:0] jb);
        logic [31:0] t;
        logic        redir;
        chk("misalign", misalign, exp_mis);
        if (bubble) chk("bubble", instr_valid, 0);
        if (instr_valid !== 1'b1) chk("nop_idle", instr_o, NOP_INSTR);
        chk("pcplus4", pcplus4_o, pc_o + 32'd4);
        redir = ps || (jj == 2'b01) || (jj == 2'b10);
        if (instr_valid === 1'b1 && !st) begin
            chk("pc_o", pc_o, mpc);
            chk("instr_o", instr_o, mem_word(mpc));
            exp_q.push_back(mpc);
            mpc = mpc + 32'd4;
            delivered++;
        end
        exp_mis = 1'b0;
        bubble  = 1'b0;
        if (redir) begin
            t       = (jj == 2'b10) ? (jb & ~32'd1) : (bp + im);
            exp_mis = t[1];
            mpc     = t & ~32'd3;
            bubble  = 1'b1;
        end
        stall = st; PCSrc = ps; J = jj; br_pc = bp; ImmExt = im; jalr_base = jb;
        imem_valid = 1'b0;
        imem_rdata = '0;
        if (stray) begin
            imem_valid = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_req === 1'b1) begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = next_lat;
                held_addr = imem_addr;
            end else begin
                chk("addr_hold", imem_addr, held_addr);
            end
            if (wait_left == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(imem_addr);
                busy       = 1'b0;
            end else begin
                wait_left--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        next_lat = 0;

        // zero-wait memory, back-to-back fetch
        do_reset();
        next_lat = 0;
        idle();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h0);
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", instr_valid, 1);
            chk("t1_pc", pc_o, 32'(i * 4));
            idle();
        end

        // response three cycles late
        do_reset();
        next_lat = 3;
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("t2_req", imem_req, 1);
            chk("t2_addr", imem_addr, 32'h0);
            chk("t2_novalid", instr_valid, 0);
            idle();
        end
        chk("t2_valid", instr_valid, 1);
        chk("t2_pc", pc_o, 32'h0);
        chk("t2_instr", instr_o, mem_word(32'h0));
        idle();
        chk("t2_nodup", instr_valid, 0);
        chk("t2_next_addr", imem_addr, 32'h4);

        // stall while a response arrives -> skid buffer
        do_reset();
        next_lat = 0;
        idle();
        idle();
        chk("t3_valid0", pc_o, 32'h0);
        step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            chk("t3_req_off", imem_req, 0);
            chk("t3_hold_instr", instr_o, mem_word(32'h0));
            chk("t3_hold_pc", pc_o, 32'h0);
            chk("t3_hold_valid", instr_valid, 1);
            step((i == 0) ? 1'b1 : 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        end
        chk("t3_skid_instr", instr_o, mem_word(32'h4));
        chk("t3_skid_pc", pc_o, 32'h4);
        chk("t3_next_addr", imem_addr, 32'h8);
        idle();
        chk("t3_pc8", pc_o, 32'h8);

        // taken branch while a request is outstanding
        do_reset();
        next_lat = 3;
        idle();
        idle();
        step(1'b0, 1'b1, 2'b00, 32'h40, 32'hFFFF_FFF8, 32'h0);
        chk("t4_addr_held", imem_addr, 32'h0);
        idle();
        next_lat = 0;
        idle();
        chk("t4_new_addr", imem_addr, 32'h38);
        chk("t4_bubble", instr_valid, 0);
        idle();
        chk("t4_pc", pc_o, 32'h38);
        chk("t4_instr", instr_o, mem_word(32'h38));

        // JALR targets: LSB cleared, bit 1 flags misalignment
        do_reset();
        next_lat = 0;
        idle();
        idle();
        step(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h101);
        chk("t5_addr", imem_addr, 32'h100);
        chk("t5_nomis", misalign, 0);
        step(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h106);
        chk("t5_mis", misalign, 1);
        chk("t5_addr2", imem_addr, 32'h104);
        idle();
        chk("t5_mis_pulse", misalign, 0);
        chk("t5_pc", pc_o, 32'h104);

        // reset in the middle of a wait, stray responses ignored
        do_reset();
        next_lat = 0;
        idle();
        idle();
        idle();
        next_lat = 6;
        idle();
        idle();
        chk("t6_in_wait", 32'(fsm_state), 32'(WAIT));
        #3;
        rst_n = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t6_async_req", imem_req, 0);
        chk("t6_async_addr", imem_addr, 32'h0);
        chk("t6_async_valid", instr_valid, 0);
        chk("t6_async_instr", instr_o, NOP_INSTR);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy = 1'b0; mpc = 32'h0; exp_mis = 1'b0; bubble = 1'b0;
        next_lat = 0;
        stray = 1'b1;
        idle();
        stray = 1'b0;
        chk("t6_first_addr", imem_addr, 32'h0);
        chk("t6_no_stray", instr_valid, 0);
        idle();
        chk("t6_first_pc", pc_o, 32'h0);
        chk("t6_first_instr", instr_o, mem_word(32'h0));

        // randomized traffic against the model
        do_reset();
        delivered = 0;
        exp_q.delete();
        for (int n = 0; n < 600; n++) begin
            logic        st, ps;
            logic [1:0]  jj;
            int          r;
            next_lat = $urandom_range(0, 3);
            st = ($urandom_range(0, 9) < 3);
            r  = $urandom_range(0, 19);
            ps = (r == 0) || (r == 4);
            jj = (r == 1) ? 2'b01 : (r == 2) ? 2'b10 : (r == 3) ? 2'b11 : 2'b00;
            step(st, ps, jj, $urandom, $urandom, $urandom);
        end
        chk("progress", 32'(delivered >= 60), 32'd1);
        chk("stream_len", 32'(exp_q.size()), 32'(delivered));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
